// File: rtl/dcpu_pkg.sv
// dcpu_pkg
// Shared definitions for the dcpu memory-bus fabric (arbiter, DMA engine,
// memory decoder).
//   OWN_CPU / OWN_DMA : bus owner encodings
//   DW                : bus data/address width
//   bus_req_t         : one master's request bundle (cs/we/addr/dat)
package dcpu_pkg;

    localparam int DW = 16;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    typedef struct packed {
        logic          cs;
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] dat;
    } bus_req_t;

    // With two masters the next owner on a handover is always the other one.
    function automatic logic other_owner(input logic owner);
        return ~owner;
    endfunction

endpackage

// File: rtl/dcpu_sat_counter.sv
// dcpu_sat_counter
// Saturating up-counter used for bus statistics.
//   i_clk   : clock
//   i_reset : asynchronous active-high reset, clears the count
//   inc     : count enable for this cycle
//   o_cnt   : current count, sticks at all-ones
module dcpu_sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_cnt <= '0;
        else if (inc && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/dcpu_bus_arbiter.sv
// dcpu_bus_arbiter
// Shares the single memory bus between the dcpu core (master 0) and the
// DMA/loader engine (master 1). The grant parks on the last owner and hands
// over only at transaction boundaries, giving round-robin under contention.
//   i_clk, i_reset            : clock, async active-high reset
//   i_m0_* / o_m0_ack         : CPU request port and its acknowledge
//   i_m1_* / o_m1_ack         : DMA request port and its acknowledge
//   o_cs/o_we/o_addr/o_dat    : slave-side request (owner's, zeroed when idle)
//   i_ack                     : slave acknowledge
//   o_owner                   : current owner (0 CPU, 1 DMA)
//   o_switch_cnt, o_wait_cnt  : saturating contention statistics
module dcpu_bus_arbiter
    import dcpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_m0_cs,
    input  logic             i_m0_we,
    input  logic [DW-1:0]    i_m0_addr,
    input  logic [DW-1:0]    i_m0_dat,
    output logic             o_m0_ack,
    input  logic             i_m1_cs,
    input  logic             i_m1_we,
    input  logic [DW-1:0]    i_m1_addr,
    input  logic [DW-1:0]    i_m1_dat,
    output logic             o_m1_ack,
    output logic             o_cs,
    output logic             o_we,
    output logic [DW-1:0]    o_addr,
    output logic [DW-1:0]    o_dat,
    input  logic             i_ack,
    output logic             o_owner,
    output logic [CNT_W-1:0] o_switch_cnt,
    output logic [CNT_W-1:0] o_wait_cnt
);

    bus_req_t m0_req, m1_req, own_req;
    logic     r_owner, nxt_owner;
    logic     own_cs, oth_cs, do_switch;

    assign m0_req = '{cs: i_m0_cs, we: i_m0_we, addr: i_m0_addr, dat: i_m0_dat};
    assign m1_req = '{cs: i_m1_cs, we: i_m1_we, addr: i_m1_addr, dat: i_m1_dat};

    // Owner register; reset abandons any transfer and hands the bus to the CPU.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_owner <= OWN_CPU;
        else
            r_owner <= nxt_owner;
    end

    // Hand over only when the other master is asking and the owner is either
    // idle or finishing its transfer this cycle. An ack with the owner idle
    // has no effect of its own: the idle owner already yields to a requester.
    always_comb begin
        own_cs    = (r_owner == OWN_DMA) ? m1_req.cs : m0_req.cs;
        oth_cs    = (r_owner == OWN_DMA) ? m0_req.cs : m1_req.cs;
        do_switch = oth_cs & (~own_cs | i_ack);
        nxt_owner = do_switch ? other_owner(r_owner) : r_owner;
    end

    // Slave-side mux and ack routing. Everything is gated by i_reset so the
    // bus goes quiet the moment reset rises, not at the next edge.
    always_comb begin
        own_req  = (r_owner == OWN_DMA) ? m1_req : m0_req;
        o_cs     = own_req.cs & ~i_reset;
        o_we     = o_cs & own_req.we;
        o_addr   = o_cs ? own_req.addr : '0;
        o_dat    = o_cs ? own_req.dat  : '0;
        o_m0_ack = i_ack & o_cs & (r_owner == OWN_CPU);
        o_m1_ack = i_ack & o_cs & (r_owner == OWN_DMA);
    end

    assign o_owner = r_owner;

    dcpu_sat_counter #(.W(CNT_W)) u_switch_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .inc     (do_switch),
        .o_cnt   (o_switch_cnt)
    );

    dcpu_sat_counter #(.W(CNT_W)) u_wait_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .inc     (oth_cs),
        .o_cnt   (o_wait_cnt)
    );

endmodule

// File: tb/tb_dcpu_bus_arbiter.sv
// tb_dcpu_bus_arbiter
// Directed bench: a table of per-cycle vectors for the main trace plus
// hand-written sequences for reset, stall/no-preemption and saturation.
// A second instance with 4-bit counters shares the same stimulus.
module tb_dcpu_bus_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        m0_cs, m0_we, m1_cs, m1_we, ack;
    logic [15:0] m0_addr, m0_dat, m1_addr, m1_dat;

    logic        o_m0_ack, o_m1_ack, o_cs, o_we, o_owner;
    logic [15:0] o_addr, o_dat, o_switch_cnt, o_wait_cnt;

    logic        s_m0_ack, s_m1_ack, s_cs, s_we, s_owner;
    logic [15:0] s_addr, s_dat;
    logic [3:0]  s_switch_cnt, s_wait_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int m0_acks  = 0;
    int m1_acks  = 0;

    always #5 i_clk = ~i_clk;

    dcpu_bus_arbiter #(.CNT_W(16)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_m0_cs(m0_cs), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_dat(m0_dat), .o_m0_ack(o_m0_ack),
        .i_m1_cs(m1_cs), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_dat(m1_dat), .o_m1_ack(o_m1_ack),
        .o_cs(o_cs), .o_we(o_we), .o_addr(o_addr), .o_dat(o_dat), .i_ack(ack),
        .o_owner(o_owner), .o_switch_cnt(o_switch_cnt), .o_wait_cnt(o_wait_cnt)
    );

    dcpu_bus_arbiter #(.CNT_W(4)) dut_sat (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_m0_cs(m0_cs), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_dat(m0_dat), .o_m0_ack(s_m0_ack),
        .i_m1_cs(m1_cs), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_dat(m1_dat), .o_m1_ack(s_m1_ack),
        .o_cs(s_cs), .o_we(s_we), .o_addr(s_addr), .o_dat(s_dat), .i_ack(ack),
        .o_owner(s_owner), .o_switch_cnt(s_switch_cnt), .o_wait_cnt(s_wait_cnt)
    );

    typedef struct packed {
        logic        m0_cs, m0_we;
        logic [15:0] m0_addr, m0_dat;
        logic        m1_cs, m1_we;
        logic [15:0] m1_addr, m1_dat;
        logic        ack;
        logic        e_cs, e_we;
        logic [15:0] e_addr, e_dat;
        logic        e_a0, e_a1, e_own;
        logic [15:0] e_sw, e_wt;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic c0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                         input logic c1, input logic w1, input logic [15:0] a1, input logic [15:0] d1,
                         input logic k);
        m0_cs = c0; m0_we = w0; m0_addr = a0; m0_dat = d0;
        m1_cs = c1; m1_we = w1; m1_addr = a1; m1_dat = d1;
        ack = k;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        // m0 read 0x0100 / m1 write 0x1234 -> 0x3000 used for round-robin
        vecs[0]  = '{1'b1,1'b0,16'h0010,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b1,
                     1'b1,1'b0,16'h0010,16'h0000, 1'b1,1'b0,1'b0, 16'd0,16'd0};
        vecs[1]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b1,16'h2000,16'hBEEF, 1'b0,
                     1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0, 16'd0,16'd0};
        vecs[2]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b1,16'h2000,16'hBEEF, 1'b1,
                     1'b1,1'b1,16'h2000,16'hBEEF, 1'b0,1'b1,1'b1, 16'd1,16'd1};
        vecs[3]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b1,
                     1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b1, 16'd1,16'd1};
        vecs[4]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,
                     1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b1, 16'd1,16'd1};
        for (int i = 0; i < 8; i++) begin
            logic own;
            own = (i % 2 == 0);  // starts with DMA owning
            vecs[5+i] = '{1'b1,1'b0,16'h0100,16'h0000, 1'b1,1'b1,16'h3000,16'h1234, 1'b1,
                          1'b1, own, own ? 16'h3000 : 16'h0100, own ? 16'h1234 : 16'h0000,
                          ~own, own, own, 16'(1+i), 16'(1+i)};
        end

        drive(0,0,0,0, 0,0,0,0, 0);
        i_reset = 1'b1;
        next_cycle();
        next_cycle();
        i_reset = 1'b0;

        // Reset asserted mid-cycle silences the bus at once
        drive(1,0,16'h0010,0, 0,0,0,0, 1);
        #2;
        check("pre_reset_cs", {31'd0, o_cs}, 1);
        i_reset = 1'b1;
        #1;
        check("reset_cs", {31'd0, o_cs}, 0);
        check("reset_ack0", {31'd0, o_m0_ack}, 0);
        check("reset_addr", {16'd0, o_addr}, 0);
        next_cycle();
        i_reset = 1'b0;
        drive(0,0,0,0, 0,0,0,0, 0);
        #4;
        check("rst_owner", {31'd0, o_owner}, 0);
        check("rst_sw", {16'd0, o_switch_cnt}, 0);
        check("rst_wt", {16'd0, o_wait_cnt}, 0);
        check("rst_wt_sat", {28'd0, s_wait_cnt}, 0);
        next_cycle();

        // Table trace: parked CPU read, DMA takeover, spurious ack, round-robin
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].m0_cs, vecs[i].m0_we, vecs[i].m0_addr, vecs[i].m0_dat,
                  vecs[i].m1_cs, vecs[i].m1_we, vecs[i].m1_addr, vecs[i].m1_dat, vecs[i].ack);
            #4;
            check($sformatf("v%0d_cs", i),    {31'd0, o_cs},      {31'd0, vecs[i].e_cs});
            check($sformatf("v%0d_we", i),    {31'd0, o_we},      {31'd0, vecs[i].e_we});
            check($sformatf("v%0d_addr", i),  {16'd0, o_addr},    {16'd0, vecs[i].e_addr});
            check($sformatf("v%0d_dat", i),   {16'd0, o_dat},     {16'd0, vecs[i].e_dat});
            check($sformatf("v%0d_ack0", i),  {31'd0, o_m0_ack},  {31'd0, vecs[i].e_a0});
            check($sformatf("v%0d_ack1", i),  {31'd0, o_m1_ack},  {31'd0, vecs[i].e_a1});
            check($sformatf("v%0d_owner", i), {31'd0, o_owner},   {31'd0, vecs[i].e_own});
            check($sformatf("v%0d_sw", i),    {16'd0, o_switch_cnt}, {16'd0, vecs[i].e_sw});
            check($sformatf("v%0d_wt", i),    {16'd0, o_wait_cnt},   {16'd0, vecs[i].e_wt});
            if (i >= 5) begin
                m0_acks += int'(o_m0_ack);
                m1_acks += int'(o_m1_ack);
            end
            next_cycle();
        end
        check("rr_m0_acks", m0_acks, 4);
        check("rr_m1_acks", m1_acks, 4);

        // No preemption: DMA owns (owner=1, sw=9, wt=9), slave stalls 5 cycles
        for (int i = 0; i < 5; i++) begin
            drive(1,1,16'h0400,16'h5555, 1,0,16'h2222,0, 0);
            #4;
            check($sformatf("stall%0d_owner", i), {31'd0, o_owner}, 1);
            check($sformatf("stall%0d_ack0", i),  {31'd0, o_m0_ack}, 0);
            check($sformatf("stall%0d_addr", i),  {16'd0, o_addr}, 32'h2222);
            next_cycle();
        end
        drive(1,1,16'h0400,16'h5555, 1,0,16'h2222,0, 1);
        #4;
        check("stall_end_ack1", {31'd0, o_m1_ack}, 1);
        check("stall_end_wt", {16'd0, o_wait_cnt}, 14);
        next_cycle();
        drive(1,1,16'h0400,16'h5555, 0,0,0,0, 0);
        #4;
        check("handover_owner", {31'd0, o_owner}, 0);
        check("handover_cs", {31'd0, o_cs}, 1);
        check("handover_addr", {16'd0, o_addr}, 32'h0400);
        check("handover_dat", {16'd0, o_dat}, 32'h5555);
        check("handover_sw", {16'd0, o_switch_cnt}, 10);
        check("handover_wt", {16'd0, o_wait_cnt}, 15);
        next_cycle();

        // DMA takes the bus, then reset mid-transfer returns it to the CPU
        drive(0,0,0,0, 1,0,16'h7000,0, 0);
        next_cycle();
        #2;
        check("pre_rst2_owner", {31'd0, o_owner}, 1);
        i_reset = 1'b1;
        #1;
        check("rst2_owner", {31'd0, o_owner}, 0);
        check("rst2_cs", {31'd0, o_cs}, 0);
        next_cycle();
        i_reset = 1'b0;

        // Saturation: CPU stalled, DMA waiting 20 cycles
        drive(1,0,16'h0008,0, 1,0,16'h7000,0, 0);
        for (int i = 0; i < 20; i++) next_cycle();
        #3;
        check("sat_owner", {31'd0, s_owner}, 0);
        check("sat_ack1", {31'd0, s_m1_ack}, 0);
        check("sat_wt16", {16'd0, o_wait_cnt}, 20);
        check("sat_wt4", {28'd0, s_wait_cnt}, 32'hF);
        check("sat_sw4", {28'd0, s_switch_cnt}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcpu_bus_arbiter.md
# dcpu_bus_arbiter

Two-master, one-slave arbiter that shares the single 16-bit memory bus between the dcpu core (master 0) and a DMA/loader engine (master 1). It sits between both masters' `cs/we/addr/dat/ack` ports and the memory or peripheral decoder. Grants are parked on the last owner and alternate round-robin at transaction boundaries. Two saturating counters provide contention statistics.

## Interface
Parameters:
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `i_clk`, in, 1: clock. All state updates on the rising edge.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_m0_cs`, `i_m0_we`, in, 1 each: CPU request and write enable.
- `i_m0_addr`, `i_m0_dat`, in, 16 each: CPU address and write data.
- `o_m0_ack`, out, 1: CPU acknowledge.
- `i_m1_cs`, `i_m1_we`, in, 1 each: DMA request and write enable.
- `i_m1_addr`, `i_m1_dat`, in, 16 each: DMA address and write data.
- `o_m1_ack`, out, 1: DMA acknowledge.
- `o_cs`, `o_we`, out, 1 each: slave request and write enable.
- `o_addr`, `o_dat`, out, 16 each: slave address and write data.
- `i_ack`, in, 1: slave acknowledge. Slave read data goes directly to both masters' data inputs and is not routed through this block.
- `o_owner`, out, 1: current owner (0 = CPU, 1 = DMA).
- `o_switch_cnt`, out, CNT_W: number of ownership changes.
- `o_wait_cnt`, out, CNT_W: number of cycles in which the non-owner had `cs` high.

## Operation
- The only arbitration state is the `r_owner` register. Its reset value is 0 (CPU).
- Slave-side outputs are combinational from the owner's inputs:
  - `o_cs = owner cs`.
  - `o_we`, `o_addr`, `o_dat` carry the owner's values when `o_cs = 1`, and are forced to 0 when `o_cs = 0`.
- Ack routing: `o_mX_ack = i_ack & (owner == X) & mX_cs`. The non-owner's ack is always 0.
- Ownership switches at the clock edge when **both** of these hold:
  - the non-owner has `cs = 1`;
  - the owner has `cs = 0`, **or** `i_ack = 1` in that cycle (its transaction completes).
- Otherwise the owner is kept, i.e. the grant stays parked on the last owner.
- A transaction is never interrupted. While the owner's `cs = 1` and `i_ack = 0`, ownership is frozen.
- Fairness: with both masters continuously requesting, ownership alternates after every acknowledged transaction (strict round-robin).
- `o_switch_cnt` increments on every ownership change and saturates at all-ones.
- `o_wait_cnt` increments in every cycle where the non-owner's `cs = 1`, and saturates at all-ones.
- Reset values:
  - `r_owner = 0`.
  - Both counters = 0.
  - While `i_reset` is high: `o_cs`, `o_we`, both acks, `o_addr` and `o_dat` are all 0.
- Reset mid-transaction: the outstanding transfer is abandoned. `o_cs` drops immediately (asynchronously) and ownership returns to the CPU.

## Timing
- Latency for the parked owner is 0: its `cs` appears on `o_cs` in the same cycle.
- Latency for the non-owner with the bus idle is 1 cycle: request at cycle n, ownership flips at the edge ending n, `o_cs` is driven from that master at n+1.
- Handover on ack: owner acked at cycle n while the other master waits. The new owner drives the slave at n+1, with no idle cycle in between.
- Simultaneous requests from both masters while the owner is idle: the owner has priority. It keeps the bus, the other master waits, and `o_wait_cnt` counts.
- An ack arriving while `o_cs = 0` (spurious ack) is ignored and causes no switch.
- There are no registered data paths. The combinational path `i_ack` → `o_mX_ack` must stay within one cycle.

## Structure
- Shared package `dcpu_pkg`:
  - `OWN_CPU = 1'b0`, `OWN_DMA = 1'b1`.
  - Bus width constant `DW = 16`.
  - Both are also used by the DMA engine and the memory decoder.
- Sub-module `dcpu_sat_counter`, parameterised by width, with inputs `inc` and asynchronous `i_reset`. It is instantiated twice, once per statistics counter.
- The arbiter proper contains only `r_owner`, the next-owner logic and the output multiplexers.

## Test plan
1. **Reset and parking.** Assert `i_reset` mid-cycle with CPU `cs = 1` → `o_cs` = 0 immediately. After release: `o_owner = 0`, counters = 0. CPU read at addr 0x0010 gets `o_cs` in the same cycle and `o_m0_ack` on `i_ack`.
2. **DMA takeover.** CPU idle, DMA writes 0xBEEF to 0x2000 at cycle n → `o_owner = 1`, `o_addr = 0x2000`, `o_dat = 0xBEEF`, `o_we = 1` at n+1. `o_switch_cnt = 1`, `o_wait_cnt = 1`.
3. **No preemption.** DMA owns the bus with the slave stalling 5 cycles. CPU raises `cs` during the stall → grant is held; `o_m0_ack` stays 0; `o_wait_cnt` +5. CPU owns the bus the cycle after the DMA ack.
4. **Round-robin.** Both masters request continuously and the slave acks every cycle → `o_owner` toggles every cycle. Each master gets exactly 4 acks in 8 cycles.
5. **Spurious ack.** `i_ack = 1` with `o_cs = 0` → both acks 0, no owner change, counters unchanged.
6. **Saturation.** `CNT_W = 4`, hold the DMA waiting for 20 cycles → `o_wait_cnt` stops at 0xF.
